// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : cpu_types_pkg                                              |
// | Description : Shared datapath/memory types. ramstate_t is the status     |
// |               reported by the RAM model; arb_state_t holds the states of |
// |               the memory arbiter FSM.                                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package cpu_types_pkg;

  // RAM status as reported on the ramstate port
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

  localparam int STREAK_W = 4;   // data-grant streak counter width
  localparam int WDT_W    = 10;  // watchdog counter width

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/mem_arb_wdt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arb_wdt                                                |
// | Description : Watchdog for the memory arbiter. Counts cycles spent in a  |
// |               granted transaction without an ACCESS response and flags   |
// |               expiry on the cycle the count reaches WDT_CYCLES.          |
// |               Only compiled when MEMARB_WDT_EN is defined.               |
// | Ports       : clk_i      clock, rising edge                              |
// |               rst_i      synchronous active-high reset                   |
// |               active_i   arbiter is in DATA or INSTR                     |
// |               access_i   RAM reports ACCESS this cycle                   |
// |               expired_o  limit reached this cycle                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`ifdef MEMARB_WDT_EN
module mem_arb_wdt
  import cpu_types_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic access_i,
  output logic expired_o
);

  // The count holds the number of waiting cycles already completed, so the
  // WDT_CYCLES-th waiting cycle is the one where the count equals LIMIT.
  localparam logic [WDT_W-1:0] LIMIT = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || access_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired_o = active_i && !access_i && (cnt_q == LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mem_arb_wdt
`endif
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                |
// | Description : Shares the single-port RAM between instruction fetch and   |
// |               data (LW/SW). Data has priority; after DATA_STREAK_MAX     |
// |               consecutive data grants with a fetch pending, the fetch is |
// |               granted. Hits are one-cycle pulses with combinational read |
// |               data. RAM errors latch a sticky err until RST.             |
// | Option      : MEMARB_WDT_EN adds a watchdog (mem_arb_wdt) that forces    |
// |               ERR after WDT_CYCLES cycles without ACCESS.                |
// | Ports       : CLK, RST               clock / sync active-high reset      |
// |               iREN, iaddr -> iload, ihit        instruction requester    |
// |               dREN, dWEN, daddr, dstore -> dload, dhit   data requester  |
// |               ramREN, ramWEN, ramaddr, ramstore  RAM request side        |
// |               ramload, ramstate                  RAM response side       |
// |               busy (DATA|INSTR), err (sticky error)                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned WDT_CYCLES      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        busy,
  output logic        err
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DATA_STREAK_MAX);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                err_q, err_d;
  logic                data_pend;
  logic                wdt_expired;

  assign data_pend = dREN | dWEN;
  assign busy      = (state_q == DATA) || (state_q == INSTR);
  assign err       = err_q;

`ifdef MEMARB_WDT_EN
  mem_arb_wdt #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk_i     (CLK),
    .rst_i     (RST),
    .active_i  (busy),
    .access_i  (ramstate == ACCESS),
    .expired_o (wdt_expired)
  );
`else
  // WDT_CYCLES is at least 1, so this is a constant 0; the parameter stays
  // referenced so both builds share one instantiation interface.
  assign wdt_expired = (WDT_CYCLES == 32'd0);
`endif

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    case (state_q)
      IDLE: begin
        // No strobes here: the grant decision only picks the next state.
        if (ramstate == ERROR) begin
          state_d = ERR;
        end else if (iREN && (!data_pend || (streak_q >= STREAK_LIMIT))) begin
          state_d = INSTR;
        end else if (data_pend) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // Strobes follow the live request so an abort drops them at once.
        if (data_pend) begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
        end
        if (ramstate == ERROR) begin
          state_d = ERR;
        end else if (!data_pend) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          state_d = IDLE;
          // A hit in the reset cycle would be lost by the requester anyway.
          if (!RST) begin
            dhit  = 1'b1;
            dload = ramload;
          end
        end else if (wdt_expired) begin
          state_d = ERR;
        end
      end
      INSTR: begin
        if (iREN) begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
        end
        if (ramstate == ERROR) begin
          state_d = ERR;
        end else if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          state_d = IDLE;
          if (!RST) begin
            ihit  = 1'b1;
            iload = ramload;
          end
        end else if (wdt_expired) begin
          state_d = ERR;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Streak of data grants taken while a fetch waits; saturates at all-ones.
  always_comb begin
    streak_d = streak_q;
    if (!iREN || ihit) begin
      streak_d = '0;
    end else if (dhit && (streak_q != '1)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  assign err_d = err_q | ((state_q != ERR) && (state_d == ERR));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                             |
// | Description : Self-checking bench for mem_arbiter with a behavioural RAM |
// |               (programmable BUSY latency, forced ERROR) and a hit        |
// |               scoreboard for dload/iload.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, busy, err;
  ramstate_t   ramstate;

  mem_arbiter #(
    .DATA_STREAK_MAX (4),
    .WDT_CYCLES      (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .ihit     (ihit),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dhit     (dhit),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .busy     (busy),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_tot  = 0;

  // ---------------- behavioural RAM ----------------
  int unsigned ram_lat;
  bit          ram_err;
  bit          mem_init;
  logic [15:0] ram_cnt;
  logic [31:0] mem [0:255];
  logic [31:0] exp_mem [0:255];

  function automatic logic [31:0] pat(input int i);
    if (i == 16) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // First strobe cycle reports FREE, then ram_lat BUSY cycles, then ACCESS.
  always_comb begin
    ramstate = FREE;
    if (ram_err) ramstate = ERROR;
    else if ((ramREN || ramWEN) && (ram_cnt != 16'd0))
      ramstate = ({16'd0, ram_cnt} <= ram_lat) ? BUSY : ACCESS;
  end

  assign ramload = mem[ramaddr[9:2]];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (ramWEN && ramstate == ACCESS) begin
      mem[ramaddr[9:2]] <= ramstore;
    end
    if (RST || !(ramREN || ramWEN) || ramstate == ACCESS) ram_cnt <= 16'd0;
    else if (ram_cnt != 16'hFFFF) ram_cnt <= ram_cnt + 16'd1;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        chk;
    logic [31:0] val;
  } sb_t;

  sb_t exp_dq[$];
  sb_t exp_iq[$];
  sb_t me;

  always @(negedge CLK) begin
    if (dhit) begin
      if (exp_dq.size() == 0) begin
        n_tot++;
        $display("FAIL dhit_unexpected: dhit=1 dload=%h, required no hit", dload);
      end else begin
        me = exp_dq.pop_front();
        if (me.chk) begin
          n_tot++;
          if (dload !== me.val) $display("FAIL dload: got %h required %h", dload, me.val);
          else n_pass++;
        end
      end
    end
    if (ihit) begin
      if (exp_iq.size() == 0) begin
        n_tot++;
        $display("FAIL ihit_unexpected: ihit=1 iload=%h, required no hit", iload);
      end else begin
        me = exp_iq.pop_front();
        if (me.chk) begin
          n_tot++;
          if (iload !== me.val) $display("FAIL iload: got %h required %h", iload, me.val);
          else n_pass++;
        end
      end
    end
  end

  // Single data transaction; returns hit latency in cycles (request cycle = 0).
  task automatic data_xact(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat);
    sb_t e;
    @(posedge CLK); #1;
    daddr = addr; dstore = wdata; dWEN = wr; dREN = rd;
    e.chk = !wr;
    e.val = exp_mem[addr[9:2]];
    if (wr) exp_mem[addr[9:2]] = wdata;
    exp_dq.push_back(e);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (dhit) begin lat = k; break; end
    end
    if (lat < 0) begin
      n_tot++;
      $display("FAIL data_timeout: no dhit for addr %h within 60 cycles", addr);
    end
    @(posedge CLK); #1;
    dREN = 1'b0; dWEN = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; mem_init = 1'b1;
    repeat (3) @(negedge CLK);
    n_tot++;
    if ({ramREN, ramWEN, ihit, dhit, busy, err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000", {ramREN, ramWEN, ihit, dhit, busy, err});
    else n_pass++;
    n_tot++;
    if ({ramaddr, ramstore} !== 64'd0)
      $display("FAIL reset_ram_bus: ramaddr %h ramstore %h required 0", ramaddr, ramstore);
    else n_pass++;
    n_tot++;
    if ({iload, dload} !== 64'd0)
      $display("FAIL reset_loads: iload %h dload %h required 0", iload, dload);
    else n_pass++;
    @(posedge CLK); #1;
    RST = 1'b0; mem_init = 1'b0;
    @(negedge CLK);
    n_tot++;
    if ({busy, err, ramREN} !== 3'b0) $display("FAIL idle_after_reset: busy/err/ramREN %b required 000", {busy, err, ramREN});
    else n_pass++;
  endtask

  task automatic test_data_read();
    int lat;
    ram_lat = 2;
    data_xact(1'b0, 1'b1, 32'h40, 32'h0, lat);
    n_tot++;
    if (lat !== 4) $display("FAIL read_latency: got %0d cycles required 4", lat);
    else n_pass++;
    @(negedge CLK);
    n_tot++;
    if (dhit !== 1'b0) $display("FAIL dhit_pulse: dhit %b one cycle later, required 0", dhit);
    else n_pass++;
  endtask

  task automatic test_priority();
    sb_t e;
    bit  got;
    ram_lat = 1;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h80;
    dWEN = 1'b1; dREN = 1'b0; daddr = 32'h44; dstore = 32'h1234;
    e.chk = 1'b0; e.val = 32'h0; exp_dq.push_back(e);
    exp_mem[17] = 32'h1234;
    e.chk = 1'b1; e.val = exp_mem[32]; exp_iq.push_back(e);
    @(negedge CLK);
    n_tot++;
    if ({ramREN, ramWEN} !== 2'b00) $display("FAIL idle_no_strobe: REN/WEN %b required 00", {ramREN, ramWEN});
    else n_pass++;
    @(negedge CLK);
    n_tot++;
    if ({ramREN, ramWEN} !== 2'b01) $display("FAIL data_first_strobe: REN/WEN %b required 01", {ramREN, ramWEN});
    else n_pass++;
    n_tot++;
    if (ramaddr !== 32'h44 || ramstore !== 32'h1234)
      $display("FAIL data_first_bus: ramaddr %h ramstore %h required 44 1234", ramaddr, ramstore);
    else n_pass++;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (dhit) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    n_tot++;
    if (!got) $display("FAIL prio_dhit: no dhit, required one");
    else n_pass++;
    @(posedge CLK); #1;
    dWEN = 1'b0;
    @(negedge CLK);   // IDLE
    @(negedge CLK);   // INSTR
    n_tot++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h80)
      $display("FAIL instr_grant: ramREN %b ramaddr %h required 1 80", ramREN, ramaddr);
    else n_pass++;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (ihit) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    n_tot++;
    if (!got) $display("FAIL prio_ihit: no ihit, required one");
    else n_pass++;
    @(posedge CLK); #1;
    iREN = 1'b0;
    @(negedge CLK);
    n_tot++;
    if (mem[17] !== 32'h1234) $display("FAIL write_landed: mem %h required 00001234", mem[17]);
    else n_pass++;
  endtask

  task automatic test_write_wins();
    int lat;
    ram_lat = 0;
    @(posedge CLK); #1;
    daddr = 32'h48; dstore = 32'hCAFE_F00D; dWEN = 1'b1; dREN = 1'b1;
    me.chk = 1'b0; me.val = 32'h0; exp_dq.push_back(me);
    exp_mem[18] = 32'hCAFE_F00D;
    @(negedge CLK);
    @(negedge CLK);
    n_tot++;
    if ({ramREN, ramWEN} !== 2'b01) $display("FAIL write_wins: REN/WEN %b required 01", {ramREN, ramWEN});
    else n_pass++;
    for (int k = 0; k < 60 && !dhit; k++) @(negedge CLK);
    @(posedge CLK); #1;
    dWEN = 1'b0; dREN = 1'b0;
    data_xact(1'b0, 1'b1, 32'h48, 32'h0, lat);
    n_tot++;
    if (lat !== 2) $display("FAIL min_latency: got %0d cycles required 2", lat);
    else n_pass++;
  endtask

  task automatic test_streak();
    sb_t ei, ed;
    int  nd_before, done_d;
    bit  got_i, to_d;
    ram_lat = 0;
    nd_before = 0; done_d = 0; got_i = 1'b0; to_d = 1'b0;
    fork
      begin
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = 32'h100;
        ei.chk = 1'b1; ei.val = exp_mem[64]; exp_iq.push_back(ei);
        for (int k = 0; k < 200; k++) begin
          @(negedge CLK);
          if (dhit) nd_before++;
          if (ihit) begin got_i = 1'b1; break; end
        end
        @(posedge CLK); #1;
        iREN = 1'b0;
      end
      begin
        for (int j = 0; j < 5; j++) begin
          @(posedge CLK); #1;
          daddr = 32'h200 + 32'(4 * j); dREN = 1'b1;
          ed.chk = 1'b1; ed.val = exp_mem[128 + j]; exp_dq.push_back(ed);
          for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (dhit) begin done_d++; break; end
            if (k == 59) to_d = 1'b1;
          end
        end
        @(posedge CLK); #1;
        dREN = 1'b0;
      end
    join
    n_tot++;
    if (!got_i || nd_before !== 4)
      $display("FAIL streak_limit: ihit %b after %0d dhits, required 1 after 4", got_i, nd_before);
    else n_pass++;
    n_tot++;
    if (to_d || done_d !== 5) $display("FAIL streak_total: %0d dhits, required 5", done_d);
    else n_pass++;
  endtask

  task automatic test_abort();
    ram_lat = 1000;
    @(posedge CLK); #1;
    daddr = 32'h60; dREN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    n_tot++;
    if (busy !== 1'b1 || ramREN !== 1'b1) $display("FAIL abort_grant: busy %b ramREN %b required 1 1", busy, ramREN);
    else n_pass++;
    @(posedge CLK); #1;
    dREN = 1'b0;
    #1;
    n_tot++;
    if (ramREN !== 1'b0) $display("FAIL abort_strobe: ramREN %b required 0", ramREN);
    else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    n_tot++;
    if (busy !== 1'b0 || dhit !== 1'b0) $display("FAIL abort_idle: busy %b dhit %b required 0 0", busy, dhit);
    else n_pass++;
  endtask

  task automatic test_error();
    ram_lat = 3;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h84;
    @(negedge CLK);
    @(negedge CLK);
    n_tot++;
    if (busy !== 1'b1) $display("FAIL err_grant: busy %b required 1", busy);
    else n_pass++;
    @(posedge CLK); #1;
    ram_err = 1'b1;
    @(posedge CLK); #1;
    ram_err = 1'b0;
    @(negedge CLK);
    n_tot++;
    if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_enter: err %b busy %b required 1 0", err, busy);
    else n_pass++;
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h40;
    repeat (5) @(negedge CLK);
    n_tot++;
    if ({err, busy, ramREN, ramWEN} !== 4'b1000)
      $display("FAIL err_sticky: err/busy/REN/WEN %b required 1000", {err, busy, ramREN, ramWEN});
    else n_pass++;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    n_tot++;
    if ({err, busy, ramREN, ramWEN, ihit, dhit, ramaddr, ramstore, iload, dload} !== 134'd0)
      $display("FAIL err_reset: err %b busy %b ramaddr %h iload %h dload %h required all 0",
               err, busy, ramaddr, iload, dload);
    else n_pass++;
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_watchdog();
    ram_lat = 1000;
    @(posedge CLK); #1;
    daddr = 32'h70; dREN = 1'b1;
`ifdef MEMARB_WDT_EN
    repeat (9) @(negedge CLK);
    n_tot++;
    if (err !== 1'b0) $display("FAIL wdt_early: err %b at cycle 8, required 0", err);
    else n_pass++;
    @(negedge CLK);
    n_tot++;
    if (err !== 1'b1 || busy !== 1'b0) $display("FAIL wdt_expire: err %b busy %b at cycle 9, required 1 0", err, busy);
    else n_pass++;
`else
    repeat (41) @(negedge CLK);
    n_tot++;
    if (err !== 1'b0 || busy !== 1'b1) $display("FAIL wait_forever: err %b busy %b, required 0 1", err, busy);
    else n_pass++;
`endif
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    dREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; mem_init = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ram_lat = 0; ram_err = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
    test_reset();
    test_data_read();
    test_priority();
    test_write_wins();
    test_streak();
    test_abort();
    test_error();
    test_watchdog();
    n_tot++;
    if (exp_dq.size() != 0 || exp_iq.size() != 0)
      $display("FAIL sb_drained: %0d data / %0d instr hits outstanding, required 0", exp_dq.size(), exp_iq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
